// File: rtl/burst_mem_responder_if.sv
// Bus bundle between the cache line adapter (master) and the burst memory responder (slave).
// bmem_err exists only when BURST_MEM_ERR_EN is defined.
interface burst_mem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] bmem_addr;
    logic                  bmem_read;
    logic                  bmem_write;
    logic [63:0]           bmem_wdata;
    logic                  bmem_ready;
    logic [ADDR_WIDTH-1:0] bmem_raddr;
    logic [63:0]           bmem_rdata;
    logic                  bmem_rvalid;
`ifdef BURST_MEM_ERR_EN
    logic                  bmem_err;
`endif

`ifdef BURST_MEM_ERR_EN
    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, bmem_err
    );
    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, bmem_err
    );
`else
    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
`endif
endinterface

// File: rtl/burst_mem_responder.sv
// 4-beat x 64-bit line memory responder with fixed read latency and registered outputs.
// Optional out-of-range address flagging is enabled by defining BURST_MEM_ERR_EN.
module burst_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_LINES  = 256,
    parameter int READ_LATENCY = 4
) (
    input logic                  clk,
    input logic                  rst,
    burst_mem_responder_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int MEM_AW = IDX_W + 2;
    localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_WAIT, S_RD_BURST} state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_beat, w_beat_nxt;
    logic [3:0]         r_lat, w_lat_nxt;
    logic [IDX_W-1:0]   r_line, w_line_nxt;
    logic               r_bad, w_bad_nxt;
    logic               w_mem_we;
    logic [MEM_AW-1:0]  w_mem_idx;

    logic               r_ready;
    logic               r_rvalid;
    logic [63:0]        r_rdata;
    logic [ADDR_WIDTH-1:0] r_raddr;

    logic [63:0]        r_mem [DEPTH_LINES*4];

    logic [IDX_W-1:0]   w_addr_line;
    logic               w_addr_bad;
    logic               w_unused_addr;

    assign w_addr_line   = bus.bmem_addr[5+IDX_W-1:5];
    assign w_unused_addr = &{1'b0, bus.bmem_addr[4:0]};

`ifdef BURST_MEM_ERR_EN
    logic r_err;
    assign w_addr_bad   = |bus.bmem_addr[ADDR_WIDTH-1:5+IDX_W];
    assign bus.bmem_err = r_err;
`else
    assign w_addr_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= 2'd0;
            r_lat   <= 4'd0;
            r_line  <= '0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_lat   <= w_lat_nxt;
            r_line  <= w_line_nxt;
            r_bad   <= w_bad_nxt;
        end
    end

    // A write wins over a simultaneous read in IDLE; the read is simply not accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_lat_nxt   = r_lat;
        w_line_nxt  = r_line;
        w_bad_nxt   = r_bad;
        w_mem_we    = 1'b0;
        w_mem_idx   = {r_line, r_beat};
        case (r_state)
            S_IDLE: begin
                if (bus.bmem_write) begin
                    w_mem_we    = !w_addr_bad;
                    w_mem_idx   = {w_addr_line, 2'd0};
                    w_line_nxt  = w_addr_line;
                    w_bad_nxt   = w_addr_bad;
                    w_beat_nxt  = 2'd1;
                    w_state_nxt = S_WR;
                end else if (bus.bmem_read) begin
                    w_line_nxt = w_addr_line;
                    w_bad_nxt  = w_addr_bad;
                    w_beat_nxt = 2'd0;
                    if (READ_LATENCY == 1) begin
                        w_state_nxt = S_RD_BURST;
                    end else begin
                        w_lat_nxt   = 4'd1;
                        w_state_nxt = S_RD_WAIT;
                    end
                end
            end
            S_WR: begin
                w_mem_we   = !r_bad;
                w_beat_nxt = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_lat_nxt   = 4'd0;
                    w_state_nxt = S_RD_BURST;
                end else begin
                    w_lat_nxt = r_lat + 4'd1;
                end
            end
            S_RD_BURST: begin
                w_beat_nxt = r_beat + 2'd1;
                if (r_beat == 2'd3) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered values line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= 64'd0;
            r_raddr  <= '0;
`ifdef BURST_MEM_ERR_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_ready  <= (w_state_nxt == S_IDLE);
            r_rvalid <= (w_state_nxt == S_RD_BURST);
            if (w_state_nxt == S_RD_BURST && !w_bad_nxt) begin
                r_rdata <= r_mem[{w_line_nxt, w_beat_nxt}];
            end else begin
                r_rdata <= 64'd0;
            end
            if (r_state == S_IDLE && !bus.bmem_write && bus.bmem_read) begin
                r_raddr <= {bus.bmem_addr[ADDR_WIDTH-1:5], 5'b0};
            end
`ifdef BURST_MEM_ERR_EN
            r_err <= (r_state == S_IDLE) && (bus.bmem_write || bus.bmem_read) && w_addr_bad;
`endif
        end
    end

    // Storage is deliberately not reset; beats already committed survive a reset.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_idx] <= bus.bmem_wdata;
        end
    end

    assign bus.bmem_ready  = r_ready;
    assign bus.bmem_rvalid = r_rvalid;
    assign bus.bmem_rdata  = r_rdata;
    assign bus.bmem_raddr  = r_raddr;
endmodule
